// File: rtl/uart_word_tx_if.sv
// Host-side bundle for uart_word_tx: write strobe and data in, FIFO/serializer status and TXD out.
interface uart_word_tx_if;
    logic        we;
    logic [31:0] data;
    logic        full;
    logic        empty;
    logic        idle;
    logic        ovf;
    logic        txd;

    modport master (output we, data, input full, empty, idle, ovf, txd);
    modport slave  (input we, data, output full, empty, idle, ovf, txd);
endinterface

// File: rtl/uart_word_tx.sv
// Buffered 32-bit word UART transmitter: words queue in a FIFO and leave as four
// back-to-back 8N1 frames, least significant byte first.
module uart_word_tx #(
    parameter int WCNT     = 868,
    parameter int DEPTH_LG = 4
) (
    input  logic          clk_i,
    input  logic          rst_x_i,
    uart_word_tx_if.slave bus
);

    localparam int                DEPTH   = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] DEPTH_V = (DEPTH_LG + 1)'(DEPTH);
    localparam logic [15:0]       WCNT_V  = 16'(WCNT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LG-1:0] wrPtr_q, rdPtr_q;
    logic [DEPTH_LG:0]   count_q;
    logic                ovf_q;
    logic                full, empty, push, pop;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [1:0]  byteIdx_q, byteIdx_d;
    logic [31:0] sreg_q, sreg_d;
    logic        txd_q, txd_d;
    logic        bitDone;

    assign full    = (count_q == DEPTH_V);
    assign empty   = (count_q == '0);
    assign push    = bus.we && !full;
    assign bitDone = (wait_q == WCNT_V);

    always_ff @(posedge clk_i) begin
        if (rst_x_i && push) begin
            mem[wrPtr_q] <= bus.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_x_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.we && full) ovf_q <= 1'b1;
        end
    end

    // TXD is registered from the current state, so every level trails the FSM by one clock.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bitIdx_d  = bitIdx_q;
        byteIdx_d = byteIdx_q;
        sreg_d    = sreg_q;
        txd_d     = 1'b1;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sreg_d    = mem[rdPtr_q];
                    byteIdx_d = 2'd0;
                    wait_d    = 16'd1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (bitDone) begin
                    wait_d   = 16'd1;
                    bitIdx_d = 3'd0;
                    state_d  = S_DATA;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DATA: begin
                txd_d = sreg_q[0];
                if (bitDone) begin
                    wait_d   = 16'd1;
                    sreg_d   = sreg_q >> 1;
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) state_d = S_STOP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bitDone) begin
                    wait_d = 16'd1;
                    if (byteIdx_q != 2'd3) begin
                        byteIdx_d = byteIdx_q + 2'd1;
                        state_d   = S_START;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        sreg_d    = mem[rdPtr_q];
                        byteIdx_d = 2'd0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_x_i) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bitIdx_q  <= '0;
            byteIdx_q <= '0;
            sreg_q    <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bitIdx_q  <= bitIdx_d;
            byteIdx_q <= byteIdx_d;
            sreg_q    <= sreg_d;
            txd_q     <= txd_d;
        end
    end

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.ovf   = ovf_q;
    assign bus.txd   = txd_q;
    assign bus.idle  = empty && (state_q == S_IDLE) && txd_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: a fast WCNT=4 instance with a serial receiver model,
// plus a WCNT=868 instance for bit-width measurement.
module tb_uart_word_tx;

    logic clk = 1'b0;
    logic rstX;
    always #5 clk = ~clk;

    uart_word_tx_if bus4();
    uart_word_tx_if bus868();

    uart_word_tx #(.WCNT(4), .DEPTH_LG(4)) dut4 (
        .clk_i(clk), .rst_x_i(rstX), .bus(bus4)
    );
    uart_word_tx #(.WCNT(868), .DEPTH_LG(4)) dut868 (
        .clk_i(clk), .rst_x_i(rstX), .bus(bus868)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int framingErrs = 0;
    logic [7:0] rxBytes[$];
    logic [7:0] expBytes[$];
    int startCyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: samples each bit in its middle clock, four clocks apart.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (bus4.txd === 1'b0) begin
                startCyc.push_back(cyc);
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = bus4.txd;
                end
                repeat (4) @(negedge clk);
                if (bus4.txd !== 1'b1) framingErrs++;
                rxBytes.push_back(b);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d);
        @(negedge clk);
        bus4.we   = 1'b1;
        bus4.data = d;
        @(posedge clk);
        #1;
        bus4.we   = 1'b0;
        bus4.data = 32'hDEADBEEF;
    endtask

    task automatic expWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) expBytes.push_back(w[8*i +: 8]);
    endtask

    task automatic clearRx();
        rxBytes.delete();
        expBytes.delete();
        startCyc.delete();
        framingErrs = 0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus4.idle !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, " idle timeout"}, 32'(n < budget), 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic waitUntilEdge(input string tag, input int t);
        checkOutput({tag, " schedule"}, 32'(cyc <= t - 1), 32'd1);
        while (cyc < t - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkBytes(input string tag);
        checkOutput({tag, " count"}, rxBytes.size(), expBytes.size());
        for (int i = 0; i < expBytes.size() && i < rxBytes.size(); i++)
            checkOutput($sformatf("%s byte%0d", tag, i), rxBytes[i], expBytes[i]);
        for (int i = 1; i < startCyc.size(); i++)
            checkOutput($sformatf("%s gap%0d", tag, i), startCyc[i] - startCyc[i-1], 32'd40);
        checkOutput({tag, " framing"}, framingErrs, 32'd0);
        clearRx();
    endtask

    task automatic measureRun868(input logic lvl, output int n);
        n = 0;
        while (bus868.txd === lvl && n < 20000) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [9:0] lvl11;
        int k, n;
        rstX = 1'b0;
        bus4.we = 1'b0;   bus4.data = '0;
        bus868.we = 1'b0; bus868.data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst txd",   bus4.txd,   1'b1);
        checkOutput("rst full",  bus4.full,  1'b0);
        checkOutput("rst empty", bus4.empty, 1'b1);
        checkOutput("rst idle",  bus4.idle,  1'b1);
        checkOutput("rst ovf",   bus4.ovf,   1'b0);
        @(negedge clk) rstX = 1'b1;
        repeat (2) @(posedge clk);

        // Single word: latency and exact level sequence of the 0x11 frame.
        expWord(32'h44332211);
        applyStimulus(32'h44332211);
        checkOutput("w1 k idle",  bus4.idle,  1'b0);
        checkOutput("w1 k empty", bus4.empty, 1'b0);
        checkOutput("w1 k txd",   bus4.txd,   1'b1);
        @(posedge clk); #1;
        checkOutput("w1 k+1 txd",   bus4.txd,   1'b1);
        checkOutput("w1 k+1 empty", bus4.empty, 1'b1);
        @(posedge clk); #1;
        lvl11 = 10'b1000100010;
        for (int j = 0; j < 10; j++) begin
            for (int o = 0; o < 4; o++) begin
                if (o == 0 || o == 3)
                    checkOutput($sformatf("w1 lvl%0d off%0d", j, o), bus4.txd, lvl11[j]);
                @(posedge clk); #1;
            end
        end
        checkOutput("w1 byte1 start", bus4.txd, 1'b0);
        waitIdle("w1", 400);
        checkBytes("w1");

        // Two back-to-back words.
        expWord(32'hA5A5A5A5);
        expWord(32'h0000FFFF);
        applyStimulus(32'hA5A5A5A5);
        applyStimulus(32'h0000FFFF);
        waitIdle("w2", 600);
        checkBytes("w2");

        // Burst of 17 while busy: 16 accepted, 17th dropped.
        expWord(32'h01020304);
        applyStimulus(32'h01020304);
        repeat (8) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expWord(32'hC0DE0000 | 32'(i * 32'h111));
            applyStimulus(32'hC0DE0000 | 32'(i * 32'h111));
            if (i == 14) checkOutput("burst full@15", bus4.full, 1'b0);
            if (i == 15) checkOutput("burst full@16", bus4.full, 1'b1);
        end
        checkOutput("burst ovf",  bus4.ovf,  1'b1);
        checkOutput("burst full", bus4.full, 1'b1);
        waitIdle("burst", 3200);
        checkBytes("burst");

        // Writes landing on pop edges.
        @(negedge clk) rstX = 1'b0;
        @(negedge clk) rstX = 1'b1;
        expWord(32'h600DF00D);
        applyStimulus(32'h600DF00D);
        k = cyc;
        waitUntilEdge("pf fill", k + 10);
        for (int i = 0; i < 16; i++) begin
            expWord(32'hB0000000 + 32'(i));
            applyStimulus(32'hB0000000 + 32'(i));
        end
        checkOutput("pf full",    bus4.full, 1'b1);
        checkOutput("pf ovf pre", bus4.ovf,  1'b0);
        waitUntilEdge("pf drop", k + 161);
        applyStimulus(32'hBADBAD00);
        checkOutput("pf drop ovf",  bus4.ovf,  1'b1);
        checkOutput("pf drop full", bus4.full, 1'b0);
        waitUntilEdge("pf acc", k + 321);
        expWord(32'h12345678);
        applyStimulus(32'h12345678);
        checkOutput("pf acc full", bus4.full, 1'b0);
        expWord(32'h9ABCDEF0);
        applyStimulus(32'h9ABCDEF0);
        checkOutput("pf refill full", bus4.full, 1'b1);
        waitIdle("pf", 3300);
        checkBytes("pf");

        // Reset in the middle of byte 2.
        applyStimulus(32'h11223344);
        repeat (100) @(posedge clk);
        checkOutput("mr ovf pre", bus4.ovf, 1'b1);
        checkOutput("mr txd pre busy", bus4.idle, 1'b0);
        @(negedge clk) rstX = 1'b0;
        @(posedge clk); #1;
        checkOutput("mr txd",   bus4.txd,   1'b1);
        checkOutput("mr empty", bus4.empty, 1'b1);
        checkOutput("mr idle",  bus4.idle,  1'b1);
        checkOutput("mr ovf",   bus4.ovf,   1'b0);
        @(negedge clk) rstX = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus4.txd !== 1'b1) n++;
        end
        checkOutput("mr quiet", n, 32'd0);
        clearRx();
        expWord(32'h5A3C0FF0);
        applyStimulus(32'h5A3C0FF0);
        waitIdle("mr", 400);
        checkBytes("mr");

        // Full-rate bit widths: byte 0x7F isolates start, bit 7 and stop.
        @(negedge clk);
        bus868.we = 1'b1;
        bus868.data = 32'h0000007F;
        @(posedge clk); #1;
        bus868.we = 1'b0;
        n = 0;
        while (bus868.txd !== 1'b0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("w868 start seen", 32'(n < 10), 32'd1);
        measureRun868(1'b0, n);
        checkOutput("w868 start width", n, 32'd868);
        measureRun868(1'b1, n);
        checkOutput("w868 bits0-6 width", n, 32'd6076);
        measureRun868(1'b0, n);
        checkOutput("w868 bit7 width", n, 32'd868);
        measureRun868(1'b1, n);
        checkOutput("w868 stop width", n, 32'd868);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
